ram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port 32-bit program/data RAM. Shares the RAM between the CPU memory port and an I/O (DMA/loader) port. Drives the RAM's address, write data, write-enable and read-enable from registers, and absorbs the RAM's one-cycle registered read latency. Returns a one-cycle ack, with read data, to the winning requester.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_pick.sv | 37 +++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   - arb_state_e : sequencer states (IDLE, ISSUE, DONE)
//   - OWN_CPU/OWN_IO : encoding of the owner/grant bit
//   - DEF_ADDR_W/DEF_DATA_W : default RAM geometry
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection for ram_arbiter.
// Ports:
//   cpu_req_i  CPU port request
//   io_req_i   I/O port request
//   owner_i    last grantee (OWN_CPU / OWN_IO)
//   grant_o    selected port; only meaningful when a request is present
// Build option: ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the port
// that is not the current owner; otherwise the CPU always wins a tie.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic io_req_i,
  input  logic owner_i,
  output logic grant_o
);

`ifndef ARB_ROUND_ROBIN_EN
  // Owner history is irrelevant when the CPU has fixed priority.
  logic unused_owner;
  assign unused_owner = owner_i;
`endif

  always_comb begin
    grant_o = OWN_CPU;
    if (cpu_req_i && io_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_o = ~owner_i;
`else
      grant_o = OWN_CPU;
`endif
    end else if (io_req_i) begin
      grant_o = OWN_IO;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port registered-read RAM between a CPU port
// and an I/O port. Each access takes three cycles: IDLE (grant + latch),
// ISSUE (RAM enable high), DONE (ack + read data to the winner).
// Ports:
//   clk, clear                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata          CPU completion pulse and read data
//   io_*                        same set for the I/O port
//   mem_addr/wdata/we/re        registered RAM controls
//   mem_rdata                   RAM output (one-cycle latency)
//   busy                        high in ISSUE and DONE
//   owner                       current/last grantee (0 = CPU, 1 = IO)
// Build option: ARB_ROUND_ROBIN_EN selects alternating tie resolution
// (see ram_arb_pick); undefined gives the CPU fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              grant;

  ram_arb_pick u_pick (
    .cpu_req_i (cpu_req),
    .io_req_i  (io_req),
    .owner_i   (owner_q),
    .grant_o   (grant)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IO;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  // Enables default low so they are high only during ISSUE; address and
  // write data hold their last value.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || io_req) begin
          owner_d = grant;
          state_d = ISSUE;
          if (grant == OWN_IO) begin
            mem_addr_d  = io_addr;
            mem_wdata_d = io_wdata;
            mem_we_d    = io_we;
            mem_re_d    = ~io_we;
          end else begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
            mem_re_d    = ~cpu_we;
          end
        end
      end
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is decoded from state so it still fires in a DONE cycle that
  // coincides with clear.
  assign cpu_ack   = (state_q == DONE) && (owner_q == OWN_CPU);
  assign io_ack    = (state_q == DONE) && (owner_q == OWN_IO);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign io_rdata  = io_ack ? mem_rdata : '0;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized dual-port traffic.
// Drivers push each issued transaction into a per-port queue; a monitor
// pops on every ack and checks read data against a word-array memory model
// updated in completion order. The monitor also predicts grants from the
// arbitration rules and checks enable/ack timing.
module tb_ram_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [7:0]  cpu_addr, io_addr;
  logic [31:0] cpu_wdata, io_wdata;
  logic        cpu_ack, io_ack;
  logic [31:0] cpu_rdata, io_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;
  logic        busy, owner;

  logic        preload;
  logic        mon_en;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  txn_t        cpu_q[$];
  txn_t        io_q[$];
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .clear(clear),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'h0980_0065;
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Single-port RAM with registered read and no reset.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else begin
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one request on a port and return at the start of the cycle after
  // its ack, with req still high (caller drops it or issues another).
  task automatic do_txn(input logic port, input logic we, input logic [7:0] a,
                        input logic [31:0] d);
    txn_t t;
    logic got;
    t.we = we; t.addr = a; t.wdata = d;
    if (port) begin
      io_req = 1'b1; io_we = we; io_addr = a; io_wdata = d; io_q.push_back(t);
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_q.push_back(t);
    end
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = port ? io_ack : cpu_ack;
    end
    chk(port ? "io_ack_seen" : "cpu_ack_seen", got, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: grant prediction, timing checks, and scoreboard pops on ack.
  initial begin : monitor
    int   phase;
    logic last_own;
    logic win;
    txn_t t;
    phase = 0;
    last_own = 1'b1;
    win = 1'b0;
    forever begin
      @(negedge clk);
      if (preload) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      end
      if (mon_en) begin
        if (phase > 0) phase--;
        if (phase == 2) begin
          // RAM enable cycle of the predicted winner.
          chk("issue_has_txn", win ? (io_q.size() != 0) : (cpu_q.size() != 0), 1);
          if (win ? (io_q.size() != 0) : (cpu_q.size() != 0)) begin
            t = win ? io_q[0] : cpu_q[0];
            chk("issue_we", mem_we, t.we);
            chk("issue_re", mem_re, !t.we);
            chk("issue_addr", mem_addr, t.addr);
            if (t.we) chk("issue_wdata", mem_wdata, t.wdata);
            chk("issue_owner", owner, win);
            chk("issue_busy", busy, 1);
            if (clear) begin
              // Access still lands in the RAM but is never acked.
              if (t.we) ref_mem[t.addr] = t.wdata;
              if (win) void'(io_q.pop_front());
              else void'(cpu_q.pop_front());
            end
          end
        end else if (phase == 1) begin
          chk("done_cpu_ack", cpu_ack, win == 1'b0);
          chk("done_io_ack", io_ack, win == 1'b1);
          chk("done_en_low", {mem_we, mem_re}, 0);
          chk("done_busy", busy, 1);
        end else begin
          chk("idle_acks", {cpu_ack, io_ack}, 0);
          chk("idle_en_low", {mem_we, mem_re}, 0);
          chk("idle_busy", busy, 0);
          if (!clear && (cpu_req || io_req)) begin
            if (cpu_req && io_req) begin
`ifdef ARB_ROUND_ROBIN_EN
              win = ~last_own;
`else
              win = 1'b0;
`endif
            end else begin
              win = io_req;
            end
            last_own = win;
            phase = 3;
          end
        end
        if (cpu_ack) begin
          chk("cpu_ack_has_txn", cpu_q.size() != 0, 1);
          if (cpu_q.size() != 0) begin
            t = cpu_q.pop_front();
            if (t.we) ref_mem[t.addr] = t.wdata;
            else chk("cpu_rdata", cpu_rdata, ref_mem[t.addr]);
            chk("io_rdata_zero", io_rdata, 0);
          end
        end
        if (io_ack) begin
          chk("io_ack_has_txn", io_q.size() != 0, 1);
          if (io_q.size() != 0) begin
            t = io_q.pop_front();
            if (t.we) ref_mem[t.addr] = t.wdata;
            else chk("io_rdata", io_rdata, ref_mem[t.addr]);
            chk("cpu_rdata_zero", cpu_rdata, 0);
          end
        end
        if (clear) begin
          phase = 0;
          last_own = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    txn_t t;
    int   first_ack;
    clear = 1'b1; preload = 1'b1; mon_en = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(posedge clk); #1 clear = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_acks", {cpu_ack, io_ack}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_io_rdata", io_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // CPU write then read back.
    do_txn(1'b0, 1'b1, 8'h54, 32'h0000_0097); cpu_req = 1'b0;
    do_txn(1'b0, 1'b0, 8'h54, 32'h0);         cpu_req = 1'b0;

    // IO read of preloaded word.
    do_txn(1'b1, 1'b0, 8'h00, 32'h0);         io_req = 1'b0;

    // Ties from a fresh reset: CPU reads 0x92 twice while IO writes it.
    clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    fork
      begin
        do_txn(1'b0, 1'b0, 8'h92, 32'h0);
        do_txn(1'b0, 1'b0, 8'h92, 32'h0);
        cpu_req = 1'b0;
      end
      begin
        do_txn(1'b1, 1'b1, 8'h92, 32'h0000_0046);
        io_req = 1'b0;
      end
    join

    // Starvation: CPU back-to-back while IO holds a read request.
    first_ack = 0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          do_txn(1'b0, 1'($urandom_range(0, 1)), 8'h40 + 8'(k), $urandom);
        cpu_req = 1'b0;
      end
      begin
        t.we = 1'b0; t.addr = 8'h33; t.wdata = '0;
        io_req = 1'b1; io_we = 1'b0; io_addr = 8'h33; io_wdata = '0;
        io_q.push_back(t);
        for (int n = 1; n <= 200 && first_ack == 0; n++) begin
          @(negedge clk);
          if (io_ack) first_ack = n;
        end
        chk("starve_io_ack_seen", first_ack != 0, 1);
        @(posedge clk); #1 io_req = 1'b0;
      end
    join
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr_io_ack_within_6", (first_ack >= 1) && (first_ack <= 6), 1);
`else
    chk("fixed_io_starved_20", first_ack > 20, 1);
`endif

    // clear during ISSUE of a CPU write.
    t.we = 1'b1; t.addr = 8'h10; t.wdata = 32'hDEAD_BEEF;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEAD_BEEF;
    cpu_q.push_back(t);
    @(posedge clk); #1 clear = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("clr_issue_we", mem_we, 1);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_no_ack", cpu_ack, 0);
    chk("clr_busy", busy, 0);
    chk("clr_en", {mem_we, mem_re}, 0);
    chk("clr_addr", mem_addr, 0);
    chk("clr_wdata", mem_wdata, 0);
    chk("clr_owner", owner, 1);
    chk("clr_cpu_q", cpu_q.size(), 0);
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 8'h10, 32'h0); cpu_req = 1'b0;

    // Idle: nothing moves; clear without traffic leaves owner at IO.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("idle_quiet", {mem_we, mem_re, busy}, 0);
    end
    chk("idle_owner_cpu", owner, 0);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_owner_after_clear", owner, 1);
    @(posedge clk); #1;

    // Randomized concurrent traffic on both ports.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          do_txn(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(32, 39)), $urandom);
          if ($urandom_range(0, 2) != 0) begin
            cpu_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
          end
        end
        cpu_req = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          do_txn(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(32, 39)), $urandom);
          if ($urandom_range(0, 2) != 0) begin
            io_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
          end
        end
        io_req = 1'b0;
      end
    join

    repeat (5) @(negedge clk);
    chk("end_cpu_q_empty", cpu_q.size(), 0);
    chk("end_io_q_empty", io_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
